serial_output: RTL and testbench
================================

Name: serial_output

Overview:
- Parallel-to-serial transmitter for the MSDAP serial link; counterpart of the serial input receiver.
- Accepts a DATA_W-bit word over a valid/ack handshake and holds it in a one-entry holding register.
- Shifts the word out LSB-first on dClk, with a frame strobe held high for exactly DATA_W bit cycles.
- Bits change on posedge dClk, so a receiver sampling on negedge dClk sees stable data.

Parameters:
- DATA_W, 40, word width in bits (MSDAP output word); legal range 2..64.
- CNT_W, $clog2(DATA_W), width of the bit counter (derived, not overridden).

Ports:
- dClk  input  1  bit clock; all state updates on posedge.
- cntrl_rst  input  1  asynchronous active-high reset.
- w_Valid  input  1  source has a word on data_In; held until ack seen.
- data_In  input  DATA_W  parallel word to transmit.
- ack  output  1  one-cycle pulse: word captured into holding register.
- frame_Out  output  1  high while a serial word is on data_Out.
- data_Out  output  1  serial data bit.
- busy  output  1  shift in progress or holding register full.
- word_Done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Reset (async assert, released synchronously by the integrator):
  - ack, frame_Out, data_Out, busy and word_Done are all 0.
  - Holding register is empty; FSM is IDLE; bit counter is 0.
  - Assertion mid-frame discards both the shifting word and the held word; frame_Out drops immediately.
- Accept (all outputs registered):
  - At posedge, if w_Valid=1, the holding register is empty and ack=0, capture data_In and set ack=1 for exactly one cycle.
  - While ack=1, w_Valid is not sampled. This prevents a double accept; the source drops or changes w_Valid after seeing ack.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT at posedge when the holding register is full. At that edge:
    - move hold to the shift register and empty the hold;
    - counter=0, frame_Out=1, data_Out=bit0.
  - SHIFT: at each posedge, counter+1 and data_Out = next bit (bit i at edge t+i for i=0..DATA_W-1). frame_Out stays 1.
  - At the last bit (counter=DATA_W-1), the next posedge:
    - pulses word_Done=1;
    - if hold is full: reloads, counter=0, data_Out=bit0 of the new word, frame_Out stays 1 (back-to-back, no gap), state stays SHIFT;
    - otherwise: frame_Out=0, data_Out=0, state -> IDLE.
- Latency: w_Valid seen at edge k -> ack high after k. From IDLE, bit0 appears after edge k+1.
- Holding register frees at the start of each word, so the next accept can happen during a shift. Sustained throughput is one word per DATA_W cycles.
- Simultaneous events:
  - A reload and an accept at the same edge are not possible: the hold empties at the reload edge and accepts only at the following edge.
  - An accept in the last-bit cycle lands in time for a back-to-back reload.
- busy = (state==SHIFT) | hold_full.
- data_Out is 0 whenever frame_Out=0.

Optional Feature:
- Macro SER_OUT_MSB_FIRST_EN.
- Defined: bit order reversed, so bit DATA_W-1 is sent first and bit 0 last.
- Undefined: LSB-first, matching the MSDAP receiver.
- Handshake, framing and timing are identical in both builds.

Decomposition:
- Shared package (msdap_pkg):
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - localparam OUT_WORD_W=40 and IN_WORD_W=16.
- No sub-module needed. The holding register is a small always_ff block inside serial_output; the FSM and shifter live in the same module.

Test Plan:
- Reset then idle, with no w_Valid for 10 cycles -> frame_Out=0, data_Out=0, ack=0, busy=0 throughout.
- Single word:
  - stimulus: w_Valid with data_In=40'h00_0000_0005;
  - ack pulses 1 cycle; frame_Out high exactly 40 cycles starting 1 cycle after ack;
  - serial bits 1,0,1,0,... then zeros; word_Done pulses once.
- Back-to-back:
  - stimulus: words 40'hAA_AAAA_AAAA then 40'h55_5555_5555, second offered during the first shift;
  - frame_Out stays high 80 consecutive cycles; two word_Done pulses 40 cycles apart; loopback receiver reconstructs both words.
- Hold-full backpressure: a third word offered while one shifts and one is held -> ack withheld until the first word's frame ends, then ack is pulsed.
- Mid-frame reset: cntrl_rst asserted at bit 17 -> frame_Out, data_Out and busy are 0 immediately; no word_Done; the next word after release transmits cleanly.
- SER_OUT_MSB_FIRST_EN build: data_In=40'h80_0000_0001 -> first bit 1, bits 1..38 are 0, last bit 1; timing identical to the LSB-first build.

Source files
------------

// File: rtl/msdap_pkg.sv
// ============================================================================
// Module   : msdap_pkg
// Purpose  : Shared types and word widths for the MSDAP serial link blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package msdap_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int OUT_WORD_W = 40;
  localparam int IN_WORD_W  = 16;

endpackage : msdap_pkg

`default_nettype wire

// File: rtl/serial_output.sv
// ============================================================================
// Module   : serial_output
// Purpose  : MSDAP parallel-to-serial transmitter with a one-entry holding
//            register; LSB-first by default, MSB-first when
//            SER_OUT_MSB_FIRST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_output
  import msdap_pkg::*;
#(
  parameter int DATA_W = OUT_WORD_W
) (
  input  logic              dClk,
  input  logic              cntrl_rst,
  input  logic              w_Valid,
  input  logic [DATA_W-1:0] data_In,
  output logic              ack,
  output logic              frame_Out,
  output logic              data_Out,
  output logic              busy,
  output logic              word_Done
);

  localparam int               CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  ser_state_t        r_state;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_data;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_last;
  logic              w_load;
  logic              w_accept;
  logic              w_first_bit;
  logic [DATA_W-1:0] w_load_rest;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_shift_next;

  assign w_last   = (r_state == SHIFT) && (r_cnt == c_LAST);
  assign w_load   = r_hold_full && ((r_state == IDLE) || w_last);
  // ack gates sampling so a source still holding w_Valid is not accepted twice
  assign w_accept = w_Valid && !r_hold_full && !ack;

`ifdef SER_OUT_MSB_FIRST_EN
  assign w_first_bit  = r_hold_data[DATA_W-1];
  assign w_load_rest  = r_hold_data << 1;
  assign w_next_bit   = r_shift[DATA_W-1];
  assign w_shift_next = r_shift << 1;
`else
  assign w_first_bit  = r_hold_data[0];
  assign w_load_rest  = r_hold_data >> 1;
  assign w_next_bit   = r_shift[0];
  assign w_shift_next = r_shift >> 1;
`endif

  assign busy = (r_state == SHIFT) || r_hold_full;

  // Holding register; accept and load are mutually exclusive on hold_full.
  always_ff @(posedge dClk or posedge cntrl_rst) begin
    if (cntrl_rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      ack         <= 1'b0;
    end else begin
      ack <= w_accept;
      if (w_accept) begin
        r_hold_data <= data_In;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge dClk or posedge cntrl_rst) begin
    if (cntrl_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      frame_Out <= 1'b0;
      data_Out  <= 1'b0;
      word_Done <= 1'b0;
    end else begin
      word_Done <= w_last;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state   <= SHIFT;
            r_shift   <= w_load_rest;
            r_cnt     <= '0;
            frame_Out <= 1'b1;
            data_Out  <= w_first_bit;
          end else begin
            frame_Out <= 1'b0;
            data_Out  <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_load) begin
              // back-to-back reload keeps the frame strobe high with no gap
              r_shift   <= w_load_rest;
              data_Out  <= w_first_bit;
              frame_Out <= 1'b1;
            end else begin
              r_state   <= IDLE;
              frame_Out <= 1'b0;
              data_Out  <= 1'b0;
            end
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_shift  <= w_shift_next;
            data_Out <= w_next_bit;
          end
        end
        default: begin
          r_state   <= IDLE;
          frame_Out <= 1'b0;
          data_Out  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_output

`default_nettype wire

// File: tb/tb_serial_output.sv
// ============================================================================
// Module   : tb_serial_output
// Purpose  : Directed self-checking bench for serial_output (either bit order,
//            selected by SER_OUT_MSB_FIRST_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_output;

  localparam int W = 40;

  logic         dClk = 1'b0;
  logic         cntrl_rst;
  logic         w_Valid;
  logic [W-1:0] data_In;
  logic         ack;
  logic         frame_Out;
  logic         data_Out;
  logic         busy;
  logic         word_Done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_output #(.DATA_W(W)) dut (
    .dClk      (dClk),
    .cntrl_rst (cntrl_rst),
    .w_Valid   (w_Valid),
    .data_In   (data_In),
    .ack       (ack),
    .frame_Out (frame_Out),
    .data_Out  (data_Out),
    .busy      (busy),
    .word_Done (word_Done)
  );

  always #5 dClk = ~dClk;

  // Element i is the bit expected on the wire in the i-th frame cycle.
  function automatic logic [W-1:0] wire_order(input logic [W-1:0] w);
    logic [W-1:0] s;
    s = '0;
`ifdef SER_OUT_MSB_FIRST_EN
    for (int i = 0; i < W; i++) s[i] = w[W-1-i];
`else
    for (int i = 0; i < W; i++) s[i] = w[i];
`endif
    return s;
  endfunction

  // Called at a negedge; returns the number of negedges until ack was seen.
  task automatic offer_word(input logic [W-1:0] w, input int limit, output int waited);
    data_In = w;
    w_Valid = 1'b1;
    waited  = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge dClk);
      if (ack === 1'b1) begin
        waited = c;
        break;
      end
    end
    w_Valid = 1'b0;
  endtask

  // Waits (bounded) for a frame, then records its bits until frame_Out drops.
  task automatic capture_frame(output int n, output logic [127:0] bits, output int dones,
                               output logic done_at_end, output int lead, output int acks);
    n     = 0;
    bits  = '0;
    dones = 0;
    lead  = 0;
    acks  = 0;
    while (frame_Out !== 1'b1 && lead < 10) begin
      @(negedge dClk);
      lead++;
    end
    while (frame_Out === 1'b1 && n < 128) begin
      bits[n] = data_Out;
      n++;
      if (word_Done === 1'b1) dones++;
      if (ack === 1'b1) acks++;
      @(negedge dClk);
    end
    done_at_end = word_Done;
    if (word_Done === 1'b1) dones++;
  endtask

  task automatic test_reset();
    cntrl_rst = 1'b1;
    w_Valid   = 1'b0;
    data_In   = '0;
    repeat (3) @(negedge dClk);
    n_checks++;
    if ({ack, frame_Out, data_Out, busy, word_Done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 00000", {ack, frame_Out, data_Out, busy, word_Done});
    end
    cntrl_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge dClk);
      n_checks++;
      if ({ack, frame_Out, data_Out, busy, word_Done} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got %b expected 00000", c, {ack, frame_Out, data_Out, busy, word_Done});
      end
    end
  endtask

  task automatic test_single_word(input logic [W-1:0] w, input string tag);
    int           waited, n, dones, lead, acks;
    logic [127:0] bits;
    logic         done_end;
    logic [W-1:0] exp_bits;
    exp_bits = wire_order(w);
    offer_word(w, 10, waited);
    n_checks++;
    if (waited != 1) begin
      n_fail++;
      $display("FAIL %s_ack_latency: got %0d expected 1", tag, waited);
    end
    capture_frame(n, bits, dones, done_end, lead, acks);
    n_checks++;
    if (lead != 1) begin
      n_fail++;
      $display("FAIL %s_frame_start: got %0d expected 1", tag, lead);
    end
    n_checks++;
    if (n != W) begin
      n_fail++;
      $display("FAIL %s_frame_len: got %0d expected %0d", tag, n, W);
    end
    n_checks++;
    if (bits[W-1:0] !== exp_bits) begin
      n_fail++;
      $display("FAIL %s_bits: got %h expected %h", tag, bits[W-1:0], exp_bits);
    end
    n_checks++;
    if (done_end !== 1'b1 || dones != 1) begin
      n_fail++;
      $display("FAIL %s_word_done: got end=%b count=%0d expected end=1 count=1", tag, done_end, dones);
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL %s_ack_single_pulse: got %0d extra acks expected 0", tag, acks);
    end
    n_checks++;
    if ({data_Out, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_after_frame: got data/busy=%b expected 00", tag, {data_Out, busy});
    end
    @(negedge dClk);
    n_checks++;
    if (word_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse_width: got %b expected 0", tag, word_Done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa, wb, ea, eb;
    logic [127:0] bits;
    int waited, n, run, maxrun, nd, d0, d1, ackb;
    wa = 40'hAA_AAAA_AAAA;
    wb = 40'h55_5555_5555;
    ea = wire_order(wa);
    eb = wire_order(wb);
    bits = '0; n = 0; run = 0; maxrun = 0; nd = 0; d0 = -1; d1 = -1; ackb = -1;
    offer_word(wa, 10, waited);
    data_In = wb;
    w_Valid = 1'b1;
    for (int cyc = 0; cyc < 85; cyc++) begin
      @(negedge dClk);
      if (w_Valid && ack === 1'b1) begin
        w_Valid = 1'b0;
        ackb    = cyc;
      end
      if (frame_Out === 1'b1) begin
        if (n < 128) bits[n] = data_Out;
        n++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (word_Done === 1'b1) begin
        if (nd == 0) d0 = cyc;
        else if (nd == 1) d1 = cyc;
        nd++;
      end
    end
    w_Valid = 1'b0;
    n_checks++;
    if (ackb != 1) begin
      n_fail++;
      $display("FAIL b2b_second_ack: got cycle %0d expected 1", ackb);
    end
    n_checks++;
    if (maxrun != 2*W || n != 2*W) begin
      n_fail++;
      $display("FAIL b2b_frame_run: got run=%0d total=%0d expected %0d", maxrun, n, 2*W);
    end
    n_checks++;
    if (nd != 2 || d0 != W || d1 != 2*W) begin
      n_fail++;
      $display("FAIL b2b_word_done: got n=%0d at %0d,%0d expected 2 at %0d,%0d", nd, d0, d1, W, 2*W);
    end
    n_checks++;
    if (bits[W-1:0] !== ea) begin
      n_fail++;
      $display("FAIL b2b_word_a: got %h expected %h", bits[W-1:0], ea);
    end
    n_checks++;
    if (bits[2*W-1:W] !== eb) begin
      n_fail++;
      $display("FAIL b2b_word_b: got %h expected %h", bits[2*W-1:W], eb);
    end
  endtask

  task automatic test_backpressure();
    int w1, w2, w3, nd;
    logic frame_at_ack3;
    offer_word(40'h11_1111_1111, 10, w1);
    offer_word(40'h22_2222_2222, 10, w2);
    offer_word(40'h33_3333_3333, 100, w3);
    frame_at_ack3 = frame_Out;
    n_checks++;
    if (w1 != 1 || w2 != 2) begin
      n_fail++;
      $display("FAIL bp_first_acks: got %0d,%0d expected 1,2", w1, w2);
    end
    n_checks++;
    if (w3 != W) begin
      n_fail++;
      $display("FAIL bp_third_ack_wait: got %0d expected %0d", w3, W);
    end
    n_checks++;
    if (frame_at_ack3 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_frame_at_ack3: got %b expected 1", frame_at_ack3);
    end
    nd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge dClk);
      if (word_Done === 1'b1) nd++;
    end
    n_checks++;
    if (nd != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got dones=%0d busy=%b expected 2 and 0", nd, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] w, ew;
    logic         pre_bit, pre_frame, stray;
    int           w1, w2;
    w  = 40'hF0_0F0F_3C96;
    ew = wire_order(w);
    offer_word(w, 10, w1);
    offer_word(40'h77_7777_7777, 10, w2);
    repeat (16) @(negedge dClk);
    pre_bit   = data_Out;
    pre_frame = frame_Out;
    n_checks++;
    if (pre_frame !== 1'b1 || pre_bit !== ew[17]) begin
      n_fail++;
      $display("FAIL mrst_bit17: got frame=%b bit=%b expected 1 %b", pre_frame, pre_bit, ew[17]);
    end
    cntrl_rst = 1'b1;
    #1;
    n_checks++;
    if ({frame_Out, data_Out, busy, ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL mrst_immediate: got %b expected 0000", {frame_Out, data_Out, busy, ack});
    end
    stray = 1'b0;
    repeat (2) begin
      @(negedge dClk);
      if (word_Done !== 1'b0) stray = 1'b1;
    end
    cntrl_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge dClk);
      if ({word_Done, busy, frame_Out} !== 3'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_discard: got activity=%b expected 0", stray);
    end
    test_single_word(40'h12_3456_789A, "after_rst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word(40'h00_0000_0005, "single");
    test_single_word(40'h80_0000_0001, "endbits");
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_output

`default_nettype wire
